// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: operand, write-back and zero-flag signals between sequencer/ALU and alu_operand_stage
interface alu_operand_stage_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
);
  logic en;
  logic flush;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [WIDTH-1:0] imm;
  logic b_sel;
  logic [2:0] op_in;
  logic s_inm_in;
  logic we3;
  logic [AW-1:0] wa3;
  logic [WIDTH-1:0] wd3;
  logic alu_zero;
  logic flag_we;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0] op_q;
  logic s_inm_q;
  logic valid_q;
  logic zero_flag;
  modport master (
    output en, flush, ra1, ra2, imm, b_sel, op_in, s_inm_in, we3, wa3, wd3, alu_zero, flag_we,
    input  a_q, b_q, op_q, s_inm_q, valid_q, zero_flag
  );
  modport slave (
    input  en, flush, ra1, ra2, imm, b_sel, op_in, s_inm_in, we3, wa3, wd3, alu_zero, flag_we,
    output a_q, b_q, op_q, s_inm_q, valid_q, zero_flag
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register bank and registered ALU operand stage; OPERAND_BYPASS_EN enables write-through forwarding
module alu_operand_stage #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input logic clk,
  input logic reset_n,
  alu_operand_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_q, b_q, rd_a, rd_b;
  logic [2:0] op_q;
  logic s_inm_q, valid_q, zero_flag, fwd_a, fwd_b, cap;
`ifdef OPERAND_BYPASS_EN
  assign fwd_a = bus.we3 && bus.wa3 == bus.ra1;
  assign fwd_b = bus.we3 && bus.wa3 == bus.ra2;
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif
  // R0 reads as zero even when a forwarded write targets it
  assign rd_a = bus.ra1 == '0 ? '0 : fwd_a ? bus.wd3 : regs[bus.ra1];
  assign rd_b = bus.ra2 == '0 ? '0 : fwd_b ? bus.wd3 : regs[bus.ra2];
  assign cap = bus.en && !bus.flush;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) regs <= '{default: '0};
    else if (bus.we3 && bus.wa3 != '0) regs[bus.wa3] <= bus.wd3;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      s_inm_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      op_q <= '0;
      valid_q <= 1'b0;
    end else if (cap) begin
      a_q <= rd_a;
      b_q <= bus.b_sel ? bus.imm : rd_b;
      op_q <= bus.op_in;
      s_inm_q <= bus.s_inm_in;
      valid_q <= 1'b1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) zero_flag <= 1'b0;
    else if (bus.flag_we) zero_flag <= bus.alu_zero;
  assign bus.a_q = a_q;
  assign bus.b_q = b_q;
  assign bus.op_q = op_q;
  assign bus.s_inm_q = s_inm_q;
  assign bus.valid_q = valid_q;
  assign bus.zero_flag = zero_flag;
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Upstream neighbour of the 16-bit ALU: register bank plus registered operand stage that drives the ALU's a, b, op_alu and s_inm inputs.
- Captures the ALU zero output into a persistent zero flag for the branch logic.
- One-cycle latency from register-address issue to operands presented at the ALU.
- Write-back port takes the ALU result, or any other write source, one cycle later.

Parameters:
WIDTH, 16, data width; must match the ALU width.
NREGS, 16, number of registers; power of two; address width AW = log2(NREGS).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
en  input  1  stage enable; 0 = stall, operand registers hold
flush  input  1  synchronous bubble insert
ra1  input  AW  read address for operand a
ra2  input  AW  read address for operand b
imm  input  WIDTH  immediate value, already extended upstream
b_sel  input  1  1 = b takes imm, 0 = b takes register ra2
op_in  input  3  ALU operation code for this instruction
s_inm_in  input  1  operand-swap selector for subtraction
we3  input  1  register write enable
wa3  input  AW  write address
wd3  input  WIDTH  write data
alu_zero  input  1  zero output from the ALU
flag_we  input  1  update zero flag this cycle
a_q  output  WIDTH  operand a to the ALU
b_q  output  WIDTH  operand b to the ALU
op_q  output  3  registered op_alu to the ALU
s_inm_q  output  1  registered s_inm to the ALU
valid_q  output  1  operands in a_q/b_q are a live instruction
zero_flag  output  1  latched zero flag

Behaviour:
- Reset (reset_n=0, asynchronous): all registers, a_q, b_q, op_q, s_inm_q, valid_q and zero_flag go to 0. Outputs are 0 while reset is held.
- R0 is hardwired to 0. Reads of address 0 return 0. Writes to wa3=0 are discarded.
- Register write: at the rising edge, if we3=1 and wa3!=0, then reg[wa3] <= wd3. Writes occur regardless of en and flush.
- Operand capture happens at the rising edge when en=1 and flush=0:
  - a_q <= rd(ra1).
  - b_q <= b_sel ? imm : rd(ra2).
  - op_q <= op_in; s_inm_q <= s_inm_in; valid_q <= 1.
- rd(x) is combinational: 0 if x=0, else reg[x], subject to bypass (see Optional Feature).
- Stall (en=0, flush=0): a_q, b_q, op_q, s_inm_q and valid_q hold.
- flush=1 has priority over en. At the edge: valid_q <= 0 and op_q <= 3'b000. a_q, b_q and s_inm_q hold.
- Zero flag: at the edge, if flag_we=1 then zero_flag <= alu_zero, else it holds. flag_we acts independently of en and flush.
- Simultaneous write and read of the same nonzero address, no bypass: the register updates at the edge and the operand captures the old value.
- No arithmetic is performed. Widths pass through unchanged, with no truncation or extension.
- Reset asserted mid-stall or mid-flush: reset wins immediately, and the stage restarts with valid_q=0.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined: when we3=1, wa3!=0 and wa3 equals ra1 (or ra2 with b_sel=0), rd() returns wd3 instead of reg[]. This is write-through forwarding, so back-to-back dependent instructions need no bubble.
- Not defined: rd() returns reg[] only. The sequencer must insert one bubble between dependent instructions.
- Both builds must pass tests 1, 2, 4, 5 and 6. Test 3 checks the feature-dependent response.

Test Plan:
1. Reset then idle: reset_n=0 for 2 cycles, then release -> a_q=b_q=0, op_q=0, valid_q=0, zero_flag=0. Read ra1=0 after any write -> a_q=0.
2. Write then read: we3=1, wa3=3, wd3=16'h1234. Next cycle ra1=3, ra2=0, b_sel=0, op_in=3'b010, en=1 -> after one edge a_q=16'h1234, b_q=0, op_q=3'b010, valid_q=1.
3. Same-cycle hazard: reg5=16'h0001. In one cycle we3=1, wa3=5, wd3=16'h00FF, ra1=5 -> a_q=16'h00FF with OPERAND_BYPASS_EN, a_q=16'h0001 without. reg5=16'h00FF afterwards in both builds.
4. Immediate select: b_sel=1, imm=16'hFFF0, ra2=3 -> b_q=16'hFFF0, independent of reg3.
5. Stall and flush: load valid instruction, then en=0 for 3 cycles while ra1 changes -> a_q held. Then flush=1 with en=1 -> valid_q=0, op_q=0, a_q held.
6. Zero flag: flag_we=1, alu_zero=1 -> zero_flag=1. flag_we=0, alu_zero=0 for 4 cycles -> zero_flag stays 1. Async reset mid-cycle -> zero_flag=0 immediately.
